ahb_mem_subsys: RTL and testbench

//  AHB-Lite slave memory subsystem: NB_BANKS SRAM banks behind one slave port.
//  - Internal address decode; built-in default slave with 2-cycle ERROR.
//  - Programmable wait states; HSIZE byte-lane writes.
//  - Replaces a fixed two-bank node plus memory arrangement; sits below the AHB node as one slave.

---
 rtl/ahb_lite_pkg.sv | 47 ++++
 rtl/ahb_sram_bank.sv | 44 ++++
 rtl/ahb_mem_subsys.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_mem_subsys.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ============================================================================
// Module      : ahb_lite_pkg
// Description : AHB-Lite transfer encodings and the byte-strobe helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // Strobe for up to a 64-bit bus; the caller keeps only its own lane count.
  function automatic logic [7:0] hsize_to_strb(input hsize_t hsize, input logic [2:0] addr_lsb);
    logic [7:0] w_base;
    case (hsize)
      HSIZE_BYTE: w_base = 8'h01;
      HSIZE_HALF: w_base = 8'h03;
      HSIZE_WORD: w_base = 8'h0F;
      default:    w_base = 8'hFF;
    endcase
    return w_base << addr_lsb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_bank.sv
// ============================================================================
// Module      : ahb_sram_bank
// Description : Single SRAM bank, byte-strobed write port, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_bank #(
  parameter int WORDS      = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read-during-write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ahb_mem_subsys.sv
// ============================================================================
// Module      : ahb_mem_subsys
// Description : AHB-Lite slave with NB_BANKS SRAM banks, wait states, ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_mem_subsys
  import ahb_lite_pkg::*;
#(
  parameter int                        NB_BANKS       = 2,
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter int                        AHB_DATA_WIDTH = 32,
  parameter int                        BANK_WORDS     = 2048,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]                i_htrans,
  input  logic                      i_hwrite,
  input  logic [2:0]                i_hsize,
  input  logic [2:0]                i_hburst,
  input  logic [3:0]                i_hprot,
  input  logic                      i_hmastlock,
  input  logic                      i_hready,
  input  logic [AHB_DATA_WIDTH-1:0] i_hwdata,
  output logic [AHB_DATA_WIDTH-1:0] o_hrdata,
  output logic                      o_hreadyout,
  output logic                      o_hresp
);

  localparam int c_nbytes     = AHB_DATA_WIDTH / 8;
  localparam int c_byte_shift = $clog2(c_nbytes);
  localparam int c_word_aw    = $clog2(BANK_WORDS);
  localparam int c_bank_shift = c_word_aw + c_byte_shift;
  localparam int c_bank_w     = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;

  localparam logic [AHB_ADDR_WIDTH:0] c_map_bytes = (AHB_ADDR_WIDTH+1)'(NB_BANKS) << c_bank_shift;
  localparam logic [2:0]              c_max_size  = 3'(c_byte_shift);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_wait = 3'd1;
  localparam logic [2:0] c_st_data = 3'd2;
  localparam logic [2:0] c_st_err1 = 3'd3;
  localparam logic [2:0] c_st_err2 = 3'd4;

  logic [2:0]                r_state;
  logic [3:0]                r_cnt;
  logic                      r_write;
  logic [c_bank_w-1:0]       r_bank;
  logic [c_word_aw-1:0]      r_word;
  logic [c_nbytes-1:0]       r_strb;
  logic                      r_fwd_valid;
  logic [AHB_DATA_WIDTH-1:0] r_fwd_data;
  logic [c_nbytes-1:0]       r_fwd_strb;
  logic [AHB_DATA_WIDTH-1:0] r_hrdata;

  htrans_t                   w_trans;
  logic [AHB_ADDR_WIDTH-1:0] w_offset;
  logic                      w_in_range;
  logic                      w_size_bad;
  logic                      w_misalign;
  logic                      w_good;
  logic [2:0]                w_lsb;
  logic [7:0]                w_strb8;
  logic [c_nbytes-1:0]       w_strb;
  logic [c_bank_w-1:0]       w_bank;
  logic [c_word_aw-1:0]      w_word;
  logic                      w_accept;
  logic                      w_open;
  logic                      w_take;
  logic                      w_commit;
  logic                      w_fwd_hit;
  logic                      w_rd_phase;
  logic [AHB_DATA_WIDTH-1:0] w_bank_rdata [NB_BANKS];
  logic [AHB_DATA_WIDTH-1:0] w_sel_rdata;
  logic [AHB_DATA_WIDTH-1:0] w_rd_word;
  logic                      w_unused;

  assign w_trans    = htrans_t'(i_htrans);
  assign w_offset   = i_haddr - BASE_ADDR;
  assign w_in_range = (i_haddr >= BASE_ADDR) && ({1'b0, w_offset} < c_map_bytes);
  assign w_size_bad = (i_hsize > c_max_size);

  always_comb begin
    w_misalign = 1'b0;
    case (i_hsize)
      3'd0:    w_misalign = 1'b0;
      3'd1:    w_misalign = i_haddr[0];
      3'd2:    w_misalign = |i_haddr[1:0];
      default: w_misalign = |i_haddr[2:0];
    endcase
  end

  assign w_good  = w_in_range && !w_size_bad && !w_misalign;
  assign w_lsb   = i_haddr[2:0] & 3'(c_nbytes - 1);
  assign w_strb8 = hsize_to_strb(hsize_t'(i_hsize), w_lsb);
  assign w_strb  = w_strb8[c_nbytes-1:0];
  assign w_bank  = c_bank_w'(w_offset >> c_bank_shift);
  assign w_word  = w_offset[c_bank_shift-1:c_byte_shift];

  // Only states driving hreadyout high can take a new address phase.
  assign w_accept = i_hsel && i_hready && ((w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ));
  assign w_open   = (r_state == c_st_idle) || (r_state == c_st_data) || (r_state == c_st_err2);
  assign w_take   = w_accept && w_open;
  assign w_commit = (r_state == c_st_data) && r_write;

  // A read landing on the word being written this edge sees stale bank data.
  assign w_fwd_hit = w_take && w_good && !i_hwrite && w_commit &&
                     (w_bank == r_bank) && (w_word == r_word);

  assign w_rd_phase = (r_state == c_st_data) && !r_write;

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_bank
    ahb_sram_bank #(
      .WORDS      (BANK_WORDS),
      .DATA_WIDTH (AHB_DATA_WIDTH),
      .ADDR_WIDTH (c_word_aw)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_commit && (r_bank == c_bank_w'(g))),
      .i_waddr (r_word),
      .i_wstrb (r_strb),
      .i_wdata (i_hwdata),
      .i_re    (w_take && w_good && !i_hwrite && (w_bank == c_bank_w'(g))),
      .i_raddr (w_word),
      .o_rdata (w_bank_rdata[g])
    );
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      if (r_bank == c_bank_w'(b)) begin
        w_sel_rdata = w_bank_rdata[b];
      end
    end
  end

  always_comb begin
    w_rd_word = w_sel_rdata;
    for (int b = 0; b < c_nbytes; b++) begin
      if (r_fwd_valid && r_fwd_strb[b]) begin
        w_rd_word[b*8 +: 8] = r_fwd_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_bank      <= '0;
      r_word      <= '0;
      r_strb      <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_data  <= '0;
      r_fwd_strb  <= '0;
      r_hrdata    <= '0;
    end else begin
      if (w_rd_phase) begin
        r_hrdata <= w_rd_word;
      end

      case (r_state)
        c_st_wait: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= c_st_data;
          end
        end
        c_st_err1: r_state <= c_st_err2;
        default: begin
          if (!w_take) begin
            r_state <= c_st_idle;
          end else if (!w_good) begin
            r_state <= c_st_err1;
          end else if (WAIT_STATES == 0) begin
            r_state <= c_st_data;
          end else begin
            r_state <= c_st_wait;
            r_cnt   <= 4'(WAIT_STATES);
          end
        end
      endcase

      if (w_take && w_good) begin
        r_write <= i_hwrite;
        r_bank  <= w_bank;
        r_word  <= w_word;
        r_strb  <= w_strb;
      end

      if (w_take) begin
        r_fwd_valid <= w_fwd_hit;
      end
      if (w_fwd_hit) begin
        r_fwd_data <= i_hwdata;
        r_fwd_strb <= r_strb;
      end
    end
  end

  assign o_hrdata    = w_rd_phase ? w_rd_word : r_hrdata;
  assign o_hreadyout = !((r_state == c_st_wait) || (r_state == c_st_err1));
  assign o_hresp     = ((r_state == c_st_err1) || (r_state == c_st_err2)) ? HRESP_ERROR : HRESP_OKAY;

  assign w_unused = ^{i_hburst, i_hprot, i_hmastlock, w_strb8};

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_subsys.sv
// ============================================================================
// Module      : tb_ahb_mem_subsys
// Description : Scoreboard bench for ahb_mem_subsys, zero and three wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_mem_subsys;
  import ahb_lite_pkg::*;

  typedef struct {
    bit          idle;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    string       tag;
  } cmd_t;

  typedef struct {
    string       tag;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        resp;
    int          waits;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hrdata0, hrdata1, hrdata;
  logic        ro0, ro1, rs0, rs1, hreadyout, hresp;

  cmd_t        cmd_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          dp_waits;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;
  assign hrdata    = sel ? hrdata1 : hrdata0;
  assign hreadyout = sel ? ro1 : ro0;
  assign hresp     = sel ? rs1 : rs0;

  ahb_mem_subsys #(
    .NB_BANKS(2), .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32),
    .BANK_WORDS(2048), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_hsel(hsel & ~sel), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_hmastlock(hmastlock), .i_hready(ro0), .i_hwdata(hwdata),
    .o_hrdata(hrdata0), .o_hreadyout(ro0), .o_hresp(rs0)
  );

  ahb_mem_subsys #(
    .NB_BANKS(2), .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32),
    .BANK_WORDS(2048), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_hsel(hsel & sel), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_hmastlock(hmastlock), .i_hready(ro1), .i_hwdata(hwdata),
    .o_hrdata(hrdata1), .o_hreadyout(ro1), .o_hresp(rs1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int key_of(input logic [31:0] addr);
    return (sel ? 32'h10000 : 32'h0) + int'(addr >> 2);
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] m;
    m = (32'd1 << s) - 32'd1;
    return (a >= 32'h4000) || (s > 3'd2) || ((a & m) != 32'd0);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    int lo, n;
    w  = model.exists(key_of(addr)) ? model[key_of(addr)] : 32'h0;
    lo = int'(addr[1:0]);
    n  = 1 << size;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) w[b*8 +: 8] = wdata[b*8 +: 8];
    end
    model[key_of(addr)] = w;
  endtask

  task automatic push_xfer(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata, input logic [1:0] trans);
    cmd_t c;
    c.idle = 1'b0; c.write = wr; c.addr = addr; c.size = size;
    c.trans = trans; c.wdata = wdata; c.tag = tag;
    cmd_q.push_back(c);
  endtask

  task automatic push_wr(input string tag, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    push_xfer(tag, 1'b1, addr, size, wdata, HTRANS_NONSEQ);
  endtask

  task automatic push_rd(input string tag, input logic [31:0] addr, input logic [1:0] trans);
    push_xfer(tag, 1'b0, addr, 3'd2, 32'h0, trans);
  endtask

  task automatic push_idle();
    cmd_t c;
    c.idle = 1'b1; c.write = 1'b0; c.addr = 32'h0; c.size = 3'd0;
    c.trans = HTRANS_IDLE; c.wdata = 32'h0; c.tag = "idle";
    cmd_q.push_back(c);
  endtask

  // One bus cycle: retire/observe the data phase, then drive the address phase.
  task automatic step();
    exp_t e;
    cmd_t c;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      hwdata = exp_q[0].wdata;
      if (hreadyout) begin
        e = exp_q.pop_front();
        check_eq({e.tag, "/resp"}, 64'(hresp), 64'(e.resp));
        check_eq({e.tag, "/waits"}, 64'(dp_waits), 64'(e.waits));
        if (!e.write && !e.resp) check_eq({e.tag, "/rdata"}, 64'(hrdata), 64'(e.data));
        if (e.write && !e.resp) model_write(e.addr, e.size, e.wdata);
        dp_waits = 0;
      end else begin
        dp_waits++;
        check_eq({exp_q[0].tag, "/wait_resp"}, 64'(hresp), 64'(exp_q[0].resp));
      end
    end
    if (cmd_q.size() > 0) begin
      c      = cmd_q[0];
      hsel   = 1'b1;
      haddr  = c.addr;
      hwrite = c.write;
      hsize  = c.size;
      htrans = c.idle ? HTRANS_IDLE : c.trans;
      if (hreadyout) begin
        void'(cmd_q.pop_front());
        if (!c.idle) begin
          e.tag   = c.tag;
          e.write = c.write;
          e.addr  = c.addr;
          e.size  = c.size;
          e.wdata = c.wdata;
          e.resp  = exp_err(c.addr, c.size);
          e.waits = e.resp ? 1 : (sel ? 3 : 0);
          e.data  = model.exists(key_of(c.addr)) ? model[key_of(c.addr)] : 32'h0;
          exp_q.push_back(e);
        end
      end
    end else begin
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_done", 64'(cmd_q.size() + exp_q.size()), 64'd0);
    cmd_q.delete();
    exp_q.delete();
    dp_waits = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0; dp_waits = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready0", 64'(ro0), 64'd1);
    check_eq("rst_resp0",  64'(rs0), 64'd0);
    check_eq("rst_rdata0", 64'(hrdata0), 64'd0);
    check_eq("rst_ready3", 64'(ro1), 64'd1);
    check_eq("rst_resp3",  64'(rs1), 64'd0);
    check_eq("rst_rdata3", 64'(hrdata1), 64'd0);
    rst_n = 1'b1;

    // Zero wait states: back-to-back write/read, byte and halfword lanes.
    push_wr("t1_wr", 32'h0, 3'd2, 32'hDEADBEEF);
    push_rd("t1_rd", 32'h0, HTRANS_NONSEQ);
    drain(20);
    push_wr("t2_wfull", 32'h2000, 3'd2, 32'h11223344);
    push_wr("t2_wbyte", 32'h2001, 3'd0, 32'hCCDDA5EE);
    push_rd("t2_rd", 32'h2000, HTRANS_NONSEQ);
    drain(20);
    @(negedge clk);
    check_eq("t2_hold", 64'(hrdata), 64'h1122A544);
    push_wr("t2_whalf", 32'h2002, 3'd1, 32'hBEEF0000);
    push_idle();
    push_rd("t2_rd2", 32'h2000, HTRANS_NONSEQ);
    drain(20);

    // Out-of-map read followed by a pipelined good read.
    push_rd("t3_oob", 32'h4000, HTRANS_NONSEQ);
    push_rd("t3_rd0", 32'h0, HTRANS_NONSEQ);
    drain(20);

    // Burst running off the top of the map.
    push_wr("tb_w0", 32'h3FF8, 3'd2, 32'hA1A2A3A4);
    push_wr("tb_w1", 32'h3FFC, 3'd2, 32'hB1B2B3B4);
    push_idle();
    push_rd("tb_r0", 32'h3FF8, HTRANS_NONSEQ);
    push_rd("tb_r1", 32'h3FFC, HTRANS_SEQ);
    push_rd("tb_r2", 32'h4000, HTRANS_SEQ);
    drain(30);

    // Misaligned and oversized transfers must leave memory alone.
    push_wr("t5_half_mis", 32'h1, 3'd1, 32'h55555555);
    push_wr("t5_size3",    32'h0, 3'd3, 32'h66666666);
    push_wr("t5_word_mis", 32'h2, 3'd2, 32'h77777777);
    push_rd("t5_rd0", 32'h0, HTRANS_NONSEQ);
    drain(30);

    // Three wait states.
    sel = 1'b1;
    push_wr("t4_wr", 32'h100, 3'd2, 32'hCAFEF00D);
    push_rd("t4_rd", 32'h100, HTRANS_NONSEQ);
    push_wr("t4_wbyte", 32'h102, 3'd0, 32'h00770000);
    push_rd("t4_rd2", 32'h100, HTRANS_NONSEQ);
    push_rd("t4_oob", 32'h8000, HTRANS_NONSEQ);
    drain(60);

    // Reset in the middle of a write's wait states.
    push_wr("t6_wr", 32'h100, 3'd2, 32'h0BADBEEF);
    step();
    step();
    check_eq("t6_in_wait", 64'(hreadyout), 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ready", 64'(hreadyout), 64'd1);
    check_eq("t6_rst_resp",  64'(hresp), 64'd0);
    check_eq("t6_rst_rdata", 64'(hrdata), 64'd0);
    exp_q.delete();
    dp_waits = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_rd("t6_rd", 32'h100, HTRANS_NONSEQ);
    drain(30);
    sel = 1'b0;
    push_rd("t6_rd_d0", 32'h2000, HTRANS_NONSEQ);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
